// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS32 core: encodings, ALU ops,
// FSM states and instruction field helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_IMMEXEC, S_IMMWB, S_BRANCH, S_JUMP, S_JR
  } state_e;

  function automatic logic [5:0] f_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] ir);
    return ir[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] ir);
    return ir[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] ir);
    return ir[15:0];
  endfunction

  function automatic logic [25:0] f_target(input logic [31:0] ir);
    return ir[25:0];
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_mem_if.sv
// Word-addressed bus between the core and its unified memory.
interface mips_mem_if #(parameter int AW = 11);
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          we;
  logic [31:0]   rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mips_unified_ram.sv
// Unified instruction/data memory: combinational read, clocked write.
// Contents are never reset so a preloaded image survives core reset.
module mips_unified_ram
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = 2048
) (
  input logic       clk,
  mips_mem_if.slave bus
);

  logic [31:0] mem [0:MEM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.addr] <= bus.wdata;
  end

  assign bus.rdata = mem[bus.addr];

endmodule

// File: rtl/mips_multi_cycle_cpu.sv
// Multi-cycle MIPS32 integer core: FSM-sequenced datapath, 32x32 register
// file and ALU, sharing one unified memory for fetch and load/store.
module mips_multi_cycle_cpu
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] regs_debug [0:31],
  output logic [31:0] pc_debug,
  output logic [31:0] instr_debug
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] rf_q [0:31];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  alu_op_e     r_op, i_op, alu_op;
  logic        r_valid, i_valid, i_zext;
  logic [31:0] imm_ext, alu_y, alu_res;
  logic        branch_taken;

  mips_mem_if #(.AW(AW)) mem_bus ();

  mips_unified_ram #(.MEM_DEPTH(MEM_DEPTH)) i_ram (
    .clk (clk),
    .bus (mem_bus.slave)
  );

  assign op    = f_op(ir_q);
  assign funct = f_funct(ir_q);
  assign rs    = f_rs(ir_q);
  assign rt    = f_rt(ir_q);
  assign rd    = f_rd(ir_q);
  assign shamt = f_shamt(ir_q);
  assign imm   = f_imm(ir_q);

  function automatic logic [31:0] alu(input alu_op_e sel, input logic [31:0] x,
                                      input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] r;
    r = '0;
    case (sel)
      ALU_ADD:  r = x + y;
      ALU_SUB:  r = x - y;
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_XOR:  r = x ^ y;
      ALU_NOR:  r = ~(x | y);
      ALU_SLT:  r = {31'd0, $signed(x) < $signed(y)};
      ALU_SLTU: r = {31'd0, x < y};
      ALU_SLL:  r = y << sh;
      ALU_SRL:  r = y >> sh;
      ALU_LUI:  r = {y[15:0], 16'h0000};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Instruction classification, shared by DECODE (dispatch) and the execute states.
  always_comb begin
    r_valid = 1'b1;
    r_op    = ALU_ADD;
    case (funct)
      F_ADD, F_ADDU: r_op = ALU_ADD;
      F_SUB, F_SUBU: r_op = ALU_SUB;
      F_AND:         r_op = ALU_AND;
      F_OR:          r_op = ALU_OR;
      F_XOR:         r_op = ALU_XOR;
      F_NOR:         r_op = ALU_NOR;
      F_SLT:         r_op = ALU_SLT;
      F_SLTU:        r_op = ALU_SLTU;
      F_SLL:         r_op = ALU_SLL;
      F_SRL:         r_op = ALU_SRL;
      default:       r_valid = 1'b0;
    endcase

    i_valid = 1'b1;
    i_op    = ALU_ADD;
    i_zext  = 1'b0;
    case (op)
      OP_ADDI, OP_ADDIU: i_op = ALU_ADD;
      OP_SLTI:           i_op = ALU_SLT;
      OP_ANDI: begin i_op = ALU_AND; i_zext = 1'b1; end
      OP_ORI:  begin i_op = ALU_OR;  i_zext = 1'b1; end
      OP_XORI: begin i_op = ALU_XOR; i_zext = 1'b1; end
      OP_LUI:            i_op = ALU_LUI;
      default:           i_valid = 1'b0;
    endcase
  end

  assign imm_ext      = i_zext ? {16'h0000, imm} : sext16(imm);
  assign alu_op       = (state_q == S_IMMEXEC) ? i_op : r_op;
  assign alu_y        = (state_q == S_IMMEXEC) ? imm_ext : b_q;
  assign alu_res      = alu(alu_op, a_q, alu_y, shamt);
  assign branch_taken = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

  // A write still pending while reset is held must not reach memory.
  assign mem_bus.addr  = (state_q == S_MEMRD || state_q == S_MEMWR) ?
                         alu_q[AW+1:2] : pc_q[AW+1:2];
  assign mem_bus.wdata = b_q;
  assign mem_bus.we    = (state_q == S_MEMWR) && reset;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;

    case (state_q)
      S_FETCH: begin
        ir_d    = mem_bus.rdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        alu_d = pc_q + (sext16(imm) << 2);
        case (op)
          OP_RTYPE: begin
            if (funct == F_JR || funct == F_JALR) state_d = S_JR;
            else if (r_valid)                     state_d = S_EXECUTE;
            else                                  state_d = S_FETCH;
          end
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:   state_d = S_JUMP;
          default:        state_d = i_valid ? S_IMMEXEC : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_d   = a_q + sext16(imm);
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mdr_d   = mem_bus.rdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEMWR: state_d = S_FETCH;
      S_EXECUTE: begin
        alu_d   = alu_res;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = S_FETCH;
      end
      S_IMMEXEC: begin
        alu_d   = alu_res;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (branch_taken) pc_d = alu_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d = {pc_q[31:28], f_target(ir_q), 2'b00};
        if (op == OP_JAL) begin
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = pc_q;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        // a_q was latched in DECODE, so rd==rs still jumps to the old value.
        pc_d = a_q;
        if (funct == F_JALR) begin
          rf_we    = 1'b1;
          rf_waddr = rd;
          rf_wdata = pc_q;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign regs_debug  = rf_q;
  assign pc_debug    = pc_q;
  assign instr_debug = ir_q;

endmodule

// File: tb/tb_mips_multi_cycle_cpu.sv
// Program-level bench: preloads small MIPS programs, runs fixed cycle
// budgets and checks registers, PC, memory and timing against hand values.
module tb_mips_multi_cycle_cpu;
  import mips_pkg::*;

  localparam int MEM_DEPTH = 2048;

  logic        clk;
  logic        reset;
  logic [31:0] regs_debug [0:31];
  logic [31:0] pc_debug;
  logic [31:0] instr_debug;

  int n_tests = 0;
  int n_fail  = 0;

  mips_multi_cycle_cpu #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .regs_debug  (regs_debug),
    .pc_debug    (pc_debug),
    .instr_debug (instr_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset and wipe memory; caller then pokes the program words.
  task automatic begin_prog();
    reset = 1'b0;
    step(1);
    for (int i = 0; i < MEM_DEPTH; i++) dut.i_ram.mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    step(1);
    reset = 1'b1;
  endtask

  logic [31:0] w0;

  initial begin
    reset = 1'b0;

    // ---------------- ALU / immediate program + reset behaviour
    begin_prog();
    w0 = i_ins(OP_ADDI, 0, 1, 16'h0005);
    dut.i_ram.mem[0]  = w0;
    dut.i_ram.mem[1]  = i_ins(OP_ADDI, 0, 2, 16'hFFFD);
    dut.i_ram.mem[2]  = r_ins(1, 2, 3, 0, F_ADD);
    dut.i_ram.mem[3]  = r_ins(2, 1, 4, 0, F_SLT);
    dut.i_ram.mem[4]  = i_ins(OP_LUI, 0, 5, 16'h1234);
    dut.i_ram.mem[5]  = i_ins(OP_ANDI, 2, 10, 16'h8001);
    dut.i_ram.mem[6]  = r_ins(2, 1, 11, 0, F_SLTU);
    dut.i_ram.mem[7]  = r_ins(1, 2, 12, 0, F_SUB);
    dut.i_ram.mem[8]  = r_ins(1, 0, 13, 0, F_NOR);
    dut.i_ram.mem[9]  = r_ins(0, 1, 14, 4, F_SLL);
    dut.i_ram.mem[10] = r_ins(0, 2, 15, 28, F_SRL);
    dut.i_ram.mem[11] = i_ins(OP_XORI, 1, 16, 16'hFFFF);
    dut.i_ram.mem[12] = i_ins(OP_SLTI, 2, 17, 16'hFFFE);
    dut.i_ram.mem[13] = r_ins(1, 5, 18, 0, F_OR);
    dut.i_ram.mem[14] = i_ins(OP_ADDIU, 1, 0, 16'h0007);
    dut.i_ram.mem[15] = j_ins(OP_J, 32'h3C);
    step(1);
    check("reset_pc", pc_debug, 32'h0);
    check("reset_ir", instr_debug, 32'h0);
    check("reset_state", 32'(dut.state_q), 32'(S_FETCH));
    for (int i = 0; i < 32; i++) check($sformatf("reset_r%0d", i), regs_debug[i], 32'h0);
    reset = 1'b1;
    step(1);
    check("first_fetch_ir", instr_debug, w0);
    check("first_fetch_pc", pc_debug, 32'h4);
    step(18);
    check("lui_not_yet", regs_debug[5], 32'h0);
    step(1);
    check("lui", regs_debug[5], 32'h12340000);
    check("addi_pos", regs_debug[1], 32'h5);
    check("addi_neg", regs_debug[2], 32'hFFFFFFFD);
    check("add", regs_debug[3], 32'h2);
    check("slt", regs_debug[4], 32'h1);
    step(40);
    check("andi_zext", regs_debug[10], 32'h00008001);
    check("sltu", regs_debug[11], 32'h0);
    check("sub", regs_debug[12], 32'h8);
    check("nor", regs_debug[13], 32'hFFFFFFFA);
    check("sll", regs_debug[14], 32'h50);
    check("srl", regs_debug[15], 32'hF);
    check("xori_zext", regs_debug[16], 32'h0000FFFA);
    check("slti", regs_debug[17], 32'h1);
    check("or", regs_debug[18], 32'h12340005);
    check("r0_zero", regs_debug[0], 32'h0);
    check("alu_pc", pc_debug, 32'd60);
    step(3);
    check("selfloop_pc", pc_debug, 32'd60);

    // ---------------- load/store, including address wrap-around
    begin_prog();
    dut.i_ram.mem[0] = i_ins(OP_ADDI, 0, 1, 16'h0005);
    dut.i_ram.mem[1] = i_ins(OP_SW, 0, 1, 16'h0100);
    dut.i_ram.mem[2] = i_ins(OP_LW, 0, 7, 16'h0100);
    dut.i_ram.mem[3] = i_ins(OP_SW, 0, 1, 16'h2104);
    dut.i_ram.mem[4] = i_ins(OP_ADDI, 0, 20, 16'h0108);
    dut.i_ram.mem[5] = i_ins(OP_LW, 20, 21, 16'hFFF8);
    dut.i_ram.mem[6] = j_ins(OP_J, 32'h18);
    release_reset();
    step(12);
    check("lw_not_yet", regs_debug[7], 32'h0);
    step(1);
    check("lw_5cyc", regs_debug[7], 32'h5);
    step(27);
    check("sw_mem", dut.i_ram.mem[64], 32'h5);
    check("sw_wrap", dut.i_ram.mem[65], 32'h5);
    check("lw_negoff", regs_debug[21], 32'h5);

    // ---------------- branches
    begin_prog();
    dut.i_ram.mem[0] = i_ins(OP_ADDI, 0, 1, 16'h0001);
    dut.i_ram.mem[1] = i_ins(OP_BEQ, 1, 1, 16'h0001);
    dut.i_ram.mem[2] = i_ins(OP_ADDI, 0, 6, 16'h0001);
    dut.i_ram.mem[3] = i_ins(OP_BNE, 1, 1, 16'h0001);
    dut.i_ram.mem[4] = i_ins(OP_ADDI, 0, 22, 16'h0007);
    dut.i_ram.mem[5] = i_ins(OP_BNE, 1, 0, 16'h0001);
    dut.i_ram.mem[6] = i_ins(OP_ADDI, 0, 6, 16'h0001);
    dut.i_ram.mem[7] = i_ins(OP_BEQ, 1, 0, 16'h0001);
    dut.i_ram.mem[8] = i_ins(OP_ADDI, 0, 23, 16'h0003);
    dut.i_ram.mem[9] = i_ins(OP_BEQ, 0, 0, 16'hFFFF);
    release_reset();
    step(7);
    check("beq_taken_pc", pc_debug, 32'd12);
    step(3);
    check("bne_nt_pc", pc_debug, 32'd16);
    step(7);
    check("bne_taken_pc", pc_debug, 32'd28);
    step(43);
    check("br_trap", regs_debug[6], 32'h0);
    check("br_r22", regs_debug[22], 32'h7);
    check("br_r23", regs_debug[23], 32'h3);
    check("br_loop_pc", pc_debug, 32'd36);

    // ---------------- jumps and links
    begin_prog();
    dut.i_ram.mem[0]  = i_ins(OP_ADDI, 0, 10, 16'h0060);
    dut.i_ram.mem[1]  = j_ins(OP_JAL, 32'h40);
    dut.i_ram.mem[2]  = r_ins(10, 0, 9, 0, F_JALR);
    dut.i_ram.mem[3]  = i_ins(OP_ADDI, 0, 25, 16'h0080);
    dut.i_ram.mem[4]  = r_ins(25, 0, 25, 0, F_JALR);
    dut.i_ram.mem[5]  = j_ins(OP_J, 32'h1C);
    dut.i_ram.mem[6]  = i_ins(OP_ADDI, 0, 6, 16'h0001);
    dut.i_ram.mem[7]  = j_ins(OP_J, 32'h1C);
    dut.i_ram.mem[16] = i_ins(OP_ADDI, 0, 8, 16'h0009);
    dut.i_ram.mem[17] = r_ins(31, 0, 0, 0, F_JR);
    dut.i_ram.mem[24] = i_ins(OP_ADDI, 0, 24, 16'h0055);
    dut.i_ram.mem[25] = r_ins(9, 0, 0, 0, F_JR);
    dut.i_ram.mem[32] = i_ins(OP_ADDI, 0, 26, 16'h0001);
    dut.i_ram.mem[33] = r_ins(25, 0, 0, 0, F_JR);
    release_reset();
    step(200);
    check("j_trap", regs_debug[6], 32'h0);
    check("jal_sub", regs_debug[8], 32'h9);
    check("jal_link", regs_debug[31], 32'h8);
    check("jalr_link", regs_debug[9], 32'hC);
    check("jalr_sub", regs_debug[24], 32'h55);
    check("jalr_rdrs_link", regs_debug[25], 32'h14);
    check("jalr_rdrs_sub", regs_debug[26], 32'h1);
    check("j_loop_pc", pc_debug, 32'h1C);

    // ---------------- reset during MEMWR of a store
    begin_prog();
    dut.i_ram.mem[0]  = i_ins(OP_ADDI, 0, 1, 16'h0005);
    dut.i_ram.mem[1]  = i_ins(OP_SW, 0, 1, 16'h0100);
    dut.i_ram.mem[2]  = j_ins(OP_J, 32'h8);
    dut.i_ram.mem[64] = 32'hDEADBEEF;
    release_reset();
    step(7);
    check("mid_in_memwr", 32'(dut.state_q), 32'(S_MEMWR));
    reset = 1'b0;
    step(1);
    check("mid_mem_kept", dut.i_ram.mem[64], 32'hDEADBEEF);
    check("mid_pc", pc_debug, 32'h0);
    check("mid_r1", regs_debug[1], 32'h0);
    check("mid_state", 32'(dut.state_q), 32'(S_FETCH));
    step(1);
    reset = 1'b1;
    step(12);
    check("restart_mem", dut.i_ram.mem[64], 32'h5);
    check("restart_r1", regs_debug[1], 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
